// File: rtl/serial_to_parallel_pkg.sv
// Shared definitions for the serial-to-parallel receiver.
// Comma character, lock depth and alignment state encoding.
package serial_to_parallel_pkg;

   localparam logic [7:0] COM_CHAR_DEF   = 8'hBC;
   localparam int         LOCK_COUNT_DEF = 4;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      ACTIVE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_to_parallel.sv
// Serial bit stream to byte deserializer with comma alignment.
// Hunts for COM_CHAR, locks after LOCK_COUNT aligned commas.
module serial_to_parallel
   import serial_to_parallel_pkg::*;
#(
   parameter logic [7:0] COM_CHAR   = COM_CHAR_DEF,
   parameter int         LOCK_COUNT = LOCK_COUNT_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active
);

   localparam int CW = $clog2(LOCK_COUNT + 1);
   localparam logic [CW-1:0] LOCK_V = CW'(LOCK_COUNT);

   state_t          state;
   state_t          state_n;
   logic [7:0]      sr;
   logic [7:0]      cand;
   logic            is_com;
   logic            boundary;
   logic [2:0]      bit_cnt;
   logic [2:0]      bit_cnt_n;
   logic [CW-1:0]   com_cnt;
   logic [CW-1:0]   com_cnt_n;
   logic [7:0]      data_n;
   logic            valid_n;

   // The byte completed by the bit arriving at this edge.
   assign cand     = {sr[6:0], data_in};
   assign is_com   = (cand == COM_CHAR);
   assign boundary = (bit_cnt == 3'd7);

   // Free-running shift register, one bit per edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sr <= '0;
      else        sr <= cand;
   end

   // Alignment decisions and byte delivery.
   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      com_cnt_n = com_cnt;
      data_n    = data_out;
      valid_n   = 1'b0;
      case (state)
         HUNT: begin
            if (is_com) begin
               state_n   = SYNC;
               com_cnt_n = CW'(1);
               bit_cnt_n = 3'd0;
            end
         end
         SYNC: begin
            bit_cnt_n = bit_cnt + 3'd1;
            if (boundary) begin
               if (is_com) begin
                  if (com_cnt != LOCK_V)
                     com_cnt_n = com_cnt + CW'(1);
                  if (com_cnt_n == LOCK_V)
                     state_n = ACTIVE;
               end else begin
                  state_n   = HUNT;
                  com_cnt_n = '0;
                  bit_cnt_n = 3'd0;
               end
            end
         end
         ACTIVE: begin
            bit_cnt_n = bit_cnt + 3'd1;
            if (boundary) begin
               data_n  = cand;
               valid_n = !is_com;
            end
         end
         default: begin
            state_n   = HUNT;
            com_cnt_n = '0;
            bit_cnt_n = 3'd0;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= HUNT;
         bit_cnt   <= 3'd0;
         com_cnt   <= '0;
         data_out  <= 8'h00;
         valid_out <= 1'b0;
         active    <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         com_cnt   <= com_cnt_n;
         data_out  <= data_n;
         valid_out <= valid_n;
         active    <= (state_n == ACTIVE);
      end
   end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Bench for serial_to_parallel: random stimulus against a
// bit-history reference model plus directed alignment cases.
module tb_serial_to_parallel;
   import serial_to_parallel_pkg::*;

   localparam logic [7:0] COM  = 8'hBC;
   localparam int         LOCK = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       data_in = 1'b0;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;

   int total = 0;
   int bad = 0;
   int steps = 0;
   logic q[$];

   logic [7:0] m_w;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_locked;
   int         m_t;
   int         m_align;
   int         m_n;

   serial_to_parallel #(
      .COM_CHAR(COM),
      .LOCK_COUNT(LOCK)
   ) dut (
      .clk(clk),
      .reset(reset),
      .data_in(data_in),
      .data_out(data_out),
      .valid_out(valid_out),
      .active(active)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired steps=%0d", steps);
      $fatal(1);
   end

   task automatic m_clear();
      m_w = 8'h00;
      m_data = 8'h00;
      m_valid = 1'b0;
      m_locked = 1'b0;
      m_t = 0;
      m_align = -1;
      m_n = 0;
   endtask

   // Reference: last 8 bits seen; alignment phase is the
   // edge index modulo 8 relative to the first comma found.
   task automatic m_step(input logic b);
      m_t++;
      m_w = {m_w[6:0], b};
      m_valid = 1'b0;
      if (m_locked) begin
         if ((m_t - m_align) % 8 == 0) begin
            m_data = m_w;
            m_valid = (m_w != COM);
         end
      end else if (m_align < 0) begin
         if (m_w == COM) begin
            m_align = m_t;
            m_n = 1;
         end
      end else if ((m_t - m_align) % 8 == 0) begin
         if (m_w == COM) begin
            m_n++;
            if (m_n == LOCK) m_locked = 1'b1;
         end else begin
            m_align = -1;
            m_n = 0;
         end
      end
   endtask

   task automatic add_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) q.push_back(v[i]);
   endtask

   task automatic drive(input logic b);
      @(negedge clk);
      data_in = b;
      @(posedge clk);
      m_step(b);
      #1;
      steps++;
   endtask

   task automatic hold_reset();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      m_clear();
      steps = 0;
      q.delete();
   endtask

   task automatic test_reset();
      m_clear();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         data_in = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         total++;
         if (data_out !== 8'h00 || valid_out !== 1'b0 || active !== 1'b0) begin
            bad++;
            $display("FAIL reset cyc=%0d got d=%h v=%b a=%b want d=00 v=0 a=0",
                     i, data_out, valid_out, active);
         end
      end
      reset = 1'b1;
   endtask

   task automatic test_lock();
      int rise = -1;
      logic [7:0] got[$];
      int at[$];
      hold_reset();
      for (int i = 0; i < 3; i++) q.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i < 4; i++) add_byte(COM);
      add_byte(8'h1A);
      add_byte(8'h2B);
      foreach (q[i]) begin
         drive(q[i]);
         total++;
         if (data_out !== m_data || valid_out !== m_valid || active !== m_locked) begin
            bad++;
            $display("FAIL lock step=%0d got d=%h v=%b a=%b want d=%h v=%b a=%b",
                     steps, data_out, valid_out, active, m_data, m_valid, m_locked);
         end
         if (active === 1'b1 && rise < 0) rise = steps;
         if (valid_out === 1'b1) begin
            got.push_back(data_out);
            at.push_back(steps);
         end
      end
      total++;
      if (rise != 35) begin
         bad++;
         $display("FAIL lock_rise got=%0d want=35", rise);
      end
      total++;
      if (got.size() != 2 || got[0] !== 8'h1A || got[1] !== 8'h2B
          || at[0] != 43 || at[1] != 51) begin
         bad++;
         $display("FAIL lock_bytes got n=%0d want 1A@43 2B@51", got.size());
      end
   endtask

   task automatic test_realign();
      int rise = -1;
      logic [7:0] got[$];
      int at[$];
      hold_reset();
      add_byte(COM);
      add_byte(COM);
      add_byte(8'h55);
      for (int i = 0; i < 4; i++) add_byte(COM);
      add_byte(8'h3C);
      foreach (q[i]) begin
         drive(q[i]);
         total++;
         if (data_out !== m_data || valid_out !== m_valid || active !== m_locked) begin
            bad++;
            $display("FAIL realign step=%0d got d=%h v=%b a=%b want d=%h v=%b a=%b",
                     steps, data_out, valid_out, active, m_data, m_valid, m_locked);
         end
         if (active === 1'b1 && rise < 0) rise = steps;
         if (valid_out === 1'b1) begin
            got.push_back(data_out);
            at.push_back(steps);
         end
      end
      total++;
      if (rise != 56) begin
         bad++;
         $display("FAIL realign_rise got=%0d want=56", rise);
      end
      total++;
      if (got.size() != 1 || got[0] !== 8'h3C || at[0] != 64) begin
         bad++;
         $display("FAIL realign_bytes got n=%0d want 3C@64", got.size());
      end
   endtask

   task automatic test_stream();
      logic [7:0] ev[3];
      logic evv[3];
      int k;
      ev = '{8'h77, COM, 8'h88};
      evv = '{1'b1, 1'b0, 1'b1};
      hold_reset();
      for (int i = 0; i < 4; i++) add_byte(COM);
      add_byte(8'h77);
      add_byte(COM);
      add_byte(8'h88);
      foreach (q[i]) begin
         drive(q[i]);
         total++;
         if (data_out !== m_data || valid_out !== m_valid || active !== m_locked) begin
            bad++;
            $display("FAIL stream step=%0d got d=%h v=%b a=%b want d=%h v=%b a=%b",
                     steps, data_out, valid_out, active, m_data, m_valid, m_locked);
         end
         if (steps >= 40 && steps % 8 == 0) begin
            k = (steps - 40) / 8;
            total++;
            if (data_out !== ev[k] || valid_out !== evv[k]) begin
               bad++;
               $display("FAIL stream_byte%0d got d=%h v=%b want d=%h v=%b",
                        k, data_out, valid_out, ev[k], evv[k]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int rise = -1;
      logic [7:0] got[$];
      int at[$];
      hold_reset();
      for (int i = 0; i < 4; i++) add_byte(COM);
      add_byte(8'hE7);
      q.push_back(1'b1);
      q.push_back(1'b0);
      q.push_back(1'b1);
      foreach (q[i]) begin
         drive(q[i]);
         total++;
         if (data_out !== m_data || valid_out !== m_valid || active !== m_locked) begin
            bad++;
            $display("FAIL mid_pre step=%0d got d=%h v=%b a=%b want d=%h v=%b a=%b",
                     steps, data_out, valid_out, active, m_data, m_valid, m_locked);
         end
      end
      #1;
      reset = 1'b0;
      #1;
      total++;
      if (data_out !== 8'h00 || valid_out !== 1'b0 || active !== 1'b0) begin
         bad++;
         $display("FAIL mid_async got d=%h v=%b a=%b want d=00 v=0 a=0",
                  data_out, valid_out, active);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      m_clear();
      steps = 0;
      q.delete();
      for (int i = 0; i < 4; i++) add_byte(COM);
      add_byte(8'hF0);
      foreach (q[i]) begin
         drive(q[i]);
         total++;
         if (data_out !== m_data || valid_out !== m_valid || active !== m_locked) begin
            bad++;
            $display("FAIL mid_post step=%0d got d=%h v=%b a=%b want d=%h v=%b a=%b",
                     steps, data_out, valid_out, active, m_data, m_valid, m_locked);
         end
         if (active === 1'b1 && rise < 0) rise = steps;
         if (valid_out === 1'b1) begin
            got.push_back(data_out);
            at.push_back(steps);
         end
      end
      total++;
      if (rise != 32 || got.size() != 1 || got[0] !== 8'hF0 || at[0] != 40) begin
         bad++;
         $display("FAIL mid_relock got rise=%0d n=%0d want rise=32 F0@40",
                  rise, got.size());
      end
   endtask

   task automatic test_shifted();
      int rise = -1;
      logic [7:0] got[$];
      int at[$];
      hold_reset();
      q.push_back(1'b0);
      for (int i = 0; i < 4; i++) add_byte(COM);
      add_byte(8'hA5);
      foreach (q[i]) begin
         drive(q[i]);
         total++;
         if (data_out !== m_data || valid_out !== m_valid || active !== m_locked) begin
            bad++;
            $display("FAIL shifted step=%0d got d=%h v=%b a=%b want d=%h v=%b a=%b",
                     steps, data_out, valid_out, active, m_data, m_valid, m_locked);
         end
         if (active === 1'b1 && rise < 0) rise = steps;
         if (valid_out === 1'b1) begin
            got.push_back(data_out);
            at.push_back(steps);
         end
      end
      total++;
      if (rise != 33 || got.size() != 1 || got[0] !== 8'hA5 || at[0] != 41) begin
         bad++;
         $display("FAIL shifted_align got rise=%0d n=%0d want rise=33 A5@41",
                  rise, got.size());
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      hold_reset();
      for (int i = 0; i < 16; i++) q.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i < 4; i++) add_byte(COM);
      for (int i = 0; i < 40; i++) begin
         b = 8'($urandom);
         if ($urandom_range(0, 3) == 0) b = COM;
         add_byte(b);
      end
      foreach (q[i]) begin
         drive(q[i]);
         total++;
         if (data_out !== m_data || valid_out !== m_valid || active !== m_locked) begin
            bad++;
            $display("FAIL random step=%0d got d=%h v=%b a=%b want d=%h v=%b a=%b",
                     steps, data_out, valid_out, active, m_data, m_valid, m_locked);
         end
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_realign();
      test_stream();
      test_reset_mid();
      test_shifted();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_to_parallel.md
SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 Parameter COM_CHAR, default 8'hBC; comma/idle symbol used for alignment and filler.
REQ-002 Parameter LOCK_COUNT, default 4; number of consecutive aligned COM_CHAR bytes required for lock.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 data_in  input  1  serial bit stream, one bit per clk, MSB of each byte first.
REQ-006 data_out  output  8  last assembled byte; feeds the 1:2 demux in0.
REQ-007 valid_out  output  1  data_out holds a non-COM payload byte this cycle; feeds the demux in0_valid.
REQ-008 active  output  1  receiver is byte-aligned and locked.

Function
REQ-009 An 8-bit shift register SHALL capture data_in every rising edge: sr <= {sr[6:0], data_in}.
REQ-010 The candidate byte SHALL be {sr[6:0], data_in}, evaluated at the same edge the bit is sampled.
REQ-011 States SHALL be HUNT, SYNC and ACTIVE; reset state is HUNT.
REQ-012 HUNT: at every edge, if candidate == COM_CHAR -> SYNC, com_cnt <= 1, bit_cnt <= 0; else remain.
REQ-013 SYNC/ACTIVE: bit_cnt SHALL increment 0..7 and wrap 7->0; a byte boundary is the edge where bit_cnt == 7.
REQ-014 SYNC, boundary, candidate == COM_CHAR: com_cnt increments; when new count == LOCK_COUNT -> ACTIVE.
REQ-015 SYNC, boundary, candidate != COM_CHAR: -> HUNT, com_cnt <= 0, bit_cnt <= 0.
REQ-016 ACTIVE, boundary: data_out <= candidate; valid_out <= (candidate != COM_CHAR).
REQ-017 valid_out SHALL be a one-cycle pulse in the cycle after a boundary edge; 0 at all other cycles.
REQ-018 Latency: byte on data_out/valid_out one cycle after the edge sampling its 8th (LSB) bit.
REQ-019 data_out SHALL hold its value between boundaries; it is not updated in HUNT or SYNC.
REQ-020 active SHALL be registered, equal to (state == ACTIVE); ACTIVE persists until reset.
REQ-021 com_cnt SHALL saturate at LOCK_COUNT; width = clog2(LOCK_COUNT+1).
REQ-022 First boundary after entering ACTIVE SHALL be 8 edges after the locking COM's last bit.

Reset
REQ-023 reset low SHALL immediately force state HUNT, sr = 0, bit_cnt = 0, com_cnt = 0, data_out = 8'h00, valid_out = 0, active = 0.
REQ-024 Reset asserted mid-byte or while ACTIVE SHALL discard partial bytes; realignment restarts from HUNT after release.
REQ-025 First edge after release SHALL sample data_in normally.

Structure
REQ-026 Shared package SHALL hold COM_CHAR default (8'hBC), LOCK_COUNT default, and the state encoding HUNT=2'd0, SYNC=2'd1, ACTIVE=2'd2.
REQ-027 Single module, no sub-module; output ports drive the 1:2 demux directly.
REQ-028 Unused state encoding 2'd3 SHALL return to HUNT.

Verification
REQ-029 Reset low 3 cycles, data_in random -> data_out=8'h00, valid_out=0, active=0 throughout.
REQ-030 After 3 garbage bits, send BC x4, then 8'h1A, 8'h2B -> active rises one cycle after 4th BC; valid_out pulses with 1A then 2B, 8 cycles apart.
REQ-031 BC x2, then 8'h55, then BC x4, 8'h3C -> return to HUNT after 55; lock only after the later four BCs; 3C delivered valid.
REQ-032 Locked, stream 8'h77, BC, 8'h88 -> data_out 77 (valid 1), BC (valid 0), 88 (valid 1).
REQ-033 Locked, reset pulsed low mid-byte -> outputs cleared immediately; after release, BC x4 then 8'hF0 -> relock, F0 valid.
REQ-034 Bit-shifted BC pattern (e.g. 8'h5E,8'h5E split across boundary) in HUNT -> aligns on the true BC bit position, not byte-zero.
